// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing the async FIFO write port.
// Each written word carries the owner's source ID in its upper bits.
module fifo_wr_arbiter #(
   parameter int NREQ  = 4,
   parameter int DSIZE = 8,
   parameter int IDW   = 2
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_last,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  wfull,
   output logic                  winc,
   output logic [IDW+DSIZE-1:0]  wdata,
   output logic [IDW-1:0]        grant_id,
   output logic                  busy
);

   localparam int IW = IDW + 1;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic             found;
   logic [IDW-1:0]   winner;
   logic [IW-1:0]    idx;
   logic [NREQ-1:0]  own_sel;
   logic             own_valid;
   logic             own_last;
   logic [DSIZE-1:0] own_data;
   logic             lock_open;
   logic [IDW-1:0]   next_ptr;

   // search rr_ptr, rr_ptr+1, ... wrapping at NREQ
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr} + IW'(k);
         if (idx >= IW'(NREQ))
            idx = idx - IW'(NREQ);
         if (!found && |(req_valid & (NREQ'(1) << idx))) begin
            found  = 1'b1;
            winner = idx[IDW-1:0];
         end
      end
   end

   // owner mux by compare so non-owner lanes never reach wdata
   always_comb begin
      own_sel   = '0;
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id == IDW'(i)) begin
            own_sel[i] = 1'b1;
            own_valid  = req_valid[i];
            own_last   = req_last[i];
            own_data   = req_data[i*DSIZE +: DSIZE];
         end
      end
   end

   always_comb begin
      lock_open = (state == LOCK) && !wfull && !wrst;
      req_ready = lock_open ? own_sel : '0;
      winc      = lock_open && own_valid;
      wdata     = winc ? {grant_id, own_data} : '0;
      next_ptr  = (grant_id == IDW'(NREQ-1)) ? '0
                                             : grant_id + IDW'(1);
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  grant_id <= winner;
                  busy     <= 1'b1;
                  state    <= LOCK;
               end
            end
            LOCK: begin
               if (winc && own_last) begin
                  rr_ptr <= next_ptr;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
